// File: rtl/in_to_fifo.sv
// Write-side bridge: captures receiver bytes into a small circular holding
// buffer and drains them into the shared FIFO with a one-cycle write strobe.
module in_to_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic [WIDTH-1:0]       in_data,
    input  logic                   in_valid,
    input  logic                   fifo_full,
    input  logic                   fifo_busy,
    input  logic                   clear_ovf,
    output logic                   fifo_we,
    output logic [WIDTH-1:0]       fifo_wdata,
    output logic                   overflow,
    output logic [CNT_W-1:0]       drop_count,
    output logic [$clog2(DEPTH):0] pending,
    output logic [1:0]             state
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        GAP   = 2'd2,
        SPARE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    wr_q, wr_d;
    logic [AW-1:0]    rd_q, rd_d;
    logic [PW-1:0]    cnt_q, cnt_d;
    logic             we_q, we_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] drops_q, drops_d;
    logic [WIDTH-1:0] buf_q [DEPTH];

    logic push, drop, pop;

    // Space is judged on pre-edge occupancy, so a same-cycle pop never frees room.
    assign push = enable && in_valid && (cnt_q < PW'(DEPTH));
    assign drop = enable && in_valid && !push;

    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        we_d    = 1'b0;
        wdata_d = wdata_q;
        ovf_d   = ovf_q;
        drops_d = drops_q;
        pop     = 1'b0;

        if (clear_ovf) begin
            ovf_d   = 1'b0;
            drops_d = '0;
        end
        if (drop) begin
            ovf_d = 1'b1;
            if (drops_d != '1) drops_d = drops_d + CNT_W'(1);
        end

        if (push) wr_d = wr_q + AW'(1);

        if (!enable) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if ((cnt_q != '0) && !fifo_full && !fifo_busy) begin
                        pop     = 1'b1;
                        we_d    = 1'b1;
                        wdata_d = buf_q[rd_q];
                        rd_d    = rd_q + AW'(1);
                        state_d = WRITE;
                    end
                end
                WRITE:   state_d = GAP;
                GAP:     state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end

        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + PW'(1);
            2'b01:   cnt_d = cnt_q - PW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            ovf_q   <= 1'b0;
            drops_q <= '0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            ovf_q   <= ovf_d;
            drops_q <= drops_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) buf_q[wr_q] <= in_data;
    end

    assign fifo_we    = we_q;
    assign fifo_wdata = wdata_q;
    assign overflow   = ovf_q;
    assign drop_count = drops_q;
    assign pending    = cnt_q;
    assign state      = state_q;

endmodule

// File: tb/tb_in_to_fifo.sv
// Bench for in_to_fifo: directed scenarios plus random traffic, all checked
// every cycle against a queue-based reference model.
module tb_in_to_fifo;

    localparam int WIDTH    = 8;
    localparam int DEPTH    = 4;
    localparam int CNT_W    = 8;
    localparam int DROP_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             r_rst, r_en, r_valid, r_full, r_busy, r_clr;
    logic [WIDTH-1:0] r_data;

    logic                   fifo_we;
    logic [WIDTH-1:0]       fifo_wdata;
    logic                   overflow;
    logic [CNT_W-1:0]       drop_count;
    logic [$clog2(DEPTH):0] pending;
    logic [1:0]             state;

    int checks   = 0;
    int failures = 0;

    logic [WIDTH-1:0] m_q[$];
    int               m_phase;
    logic             m_we;
    logic [WIDTH-1:0] m_wdata;
    logic             m_ovf;
    int               m_drops;

    in_to_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (r_rst),
        .enable     (r_en),
        .in_data    (r_data),
        .in_valid   (r_valid),
        .fifo_full  (r_full),
        .fifo_busy  (r_busy),
        .clear_ovf  (r_clr),
        .fifo_we    (fifo_we),
        .fifo_wdata (fifo_wdata),
        .overflow   (overflow),
        .drop_count (drop_count),
        .pending    (pending),
        .state      (state)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Phase 0 = ready to write, 1 = strobe cycle, 2 = recovery cycle.
    task automatic model_edge();
        bit accept, dropped, issue;
        if (r_rst) begin
            m_q.delete();
            m_we = 0; m_wdata = '0; m_ovf = 0; m_drops = 0; m_phase = 0;
            return;
        end
        if (r_clr) begin
            m_ovf = 0; m_drops = 0;
        end
        if (!r_en) begin
            m_we = 0; m_phase = 0;
            return;
        end
        accept  = r_valid && (m_q.size() < DEPTH);
        dropped = r_valid && !accept;
        if (dropped) begin
            m_ovf = 1;
            if (m_drops < DROP_MAX) m_drops++;
        end
        issue = (m_phase == 0) && (m_q.size() > 0) && !r_full && !r_busy;
        m_we = issue;
        if (issue) m_wdata = m_q.pop_front();
        m_phase = issue ? 1 : ((m_phase == 1) ? 2 : 0);
        if (accept) m_q.push_back(r_data);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_eq("fifo_we",    fifo_we,    m_we);
        check_eq("fifo_wdata", fifo_wdata, m_wdata);
        check_eq("pending",    pending,    m_q.size());
        check_eq("overflow",   overflow,   m_ovf);
        check_eq("drop_count", drop_count, m_drops);
        check_eq("state",      state,      m_phase);
    endtask

    task automatic cyc(input bit rst_v, input bit en_v, input bit val_v, input logic [WIDTH-1:0] d,
                       input bit full_v, input bit busy_v, input bit clr_v);
        r_rst = rst_v; r_en = en_v; r_valid = val_v; r_data = d;
        r_full = full_v; r_busy = busy_v; r_clr = clr_v;
        tick();
    endtask

    task automatic idle(input int n, input bit full_v);
        for (int i = 0; i < n; i++) cyc(0, 1, 0, '0, full_v, 0, 0);
    endtask

    initial begin
        int lat;
        r_rst = 1; r_en = 0; r_valid = 0; r_data = '0; r_full = 0; r_busy = 0; r_clr = 0;
        m_phase = 0; m_we = 0; m_wdata = '0; m_ovf = 0; m_drops = 0;

        cyc(1, 0, 0, '0, 0, 0, 0);
        cyc(1, 1, 0, '0, 0, 0, 0);

        // Single byte latency
        cyc(0, 1, 1, 8'hA5, 0, 0, 0);
        lat = 0;
        for (int i = 0; i < 10 && !fifo_we; i++) begin
            cyc(0, 1, 0, '0, 0, 0, 0);
            lat++;
        end
        check_eq("latency", lat, 1);
        check_eq("first_byte", fifo_wdata, 8'hA5);
        idle(4, 0);

        // Stall with full FIFO, overflow on fifth byte, then drain
        for (int i = 1; i <= 4; i++) cyc(0, 1, 1, WIDTH'(i), 1, 0, 0);
        idle(2, 1);
        cyc(0, 1, 1, 8'h05, 1, 0, 0);
        idle(2, 1);
        idle(16, 0);

        // Wrap-around stream
        for (int i = 0; i < 10; i++) begin
            cyc(0, 1, 1, WIDTH'(8'h40 + i), 0, 0, 0);
            idle(2, 0);
        end
        idle(6, 0);

        // Push coincident with pop at pending=2
        cyc(0, 1, 1, 8'h61, 1, 0, 1);
        cyc(0, 1, 1, 8'h62, 1, 0, 0);
        cyc(0, 1, 1, 8'h63, 0, 0, 0);
        idle(12, 0);

        // Disabled capture
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, 8'h77, 0, 0, 0);
        idle(3, 0);

        // clear_ovf coincident with a drop, then saturation
        for (int i = 0; i < 4; i++) cyc(0, 1, 1, WIDTH'(8'h80 + i), 1, 0, 0);
        cyc(0, 1, 1, 8'h90, 1, 0, 0);
        cyc(0, 1, 1, 8'h91, 1, 0, 1);
        check_eq("clr_drop_count", drop_count, 1);
        for (int i = 0; i < 300; i++) cyc(0, 1, 1, WIDTH'(i), 1, 0, 0);
        check_eq("drop_sat", drop_count, DROP_MAX);
        idle(16, 0);

        // Reset mid-write
        cyc(0, 1, 1, 8'hC3, 0, 0, 0);
        for (int i = 0; i < 10 && m_phase != 1; i++) cyc(0, 1, 0, '0, 0, 0, 0);
        check_eq("in_write", state, 1);
        cyc(1, 1, 0, '0, 0, 0, 0);
        check_eq("rst_we", fifo_we, 0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) != 0), $urandom_range(0, 1),
                WIDTH'($urandom), ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0),
                ($urandom_range(0, 39) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
